// File: rtl/packet_pkg.sv
// Shared packet definitions for the switch port receive path.
package packet_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int SRC_W      = 2;
  localparam int PKT_DATA_W = 8;

  typedef enum logic [1:0] {
    PKT_DATA = 2'd0,
    PKT_CTRL = 2'd1,
    PKT_MGMT = 2'd2,
    PKT_IDLE = 2'd3
  } pkt_type_e;

  // Default-width entry; the receiver rebuilds the same layout at its own DATA_W.
  typedef struct packed {
    logic [SRC_W-1:0]      source;
    pkt_type_e             ptype;
    logic [PKT_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with a registered read port; full/empty follow the occupancy count.
module rx_fifo
  import packet_pkg::*;
#(
  parameter type entry_t = rx_entry_t,
  parameter int  DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output logic             rd_valid_o,
  output entry_t           rd_data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               rd_valid_q, rd_valid_d;
  entry_t             rd_data_q, rd_data_d;
  logic               pop_ok;

  // A pop is judged against the pre-cycle empty flag, so push+pop on empty only pushes.
  assign pop_ok = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = pop_ok;
    rd_data_d  = rd_data_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    level_d = level_q + LVL_W'(push_i) - LVL_W'(pop_ok);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/switch_port_rx.sv
// Egress receiver for one switch port: route check, buffering and saturating statistics.
module switch_port_rx
  import packet_pkg::*;
#(
  parameter int  PORT_ID = 0,
  parameter int  DATA_W  = 8,
  parameter int  DEPTH   = 8,
  parameter int  CNT_W   = 16,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_i,
  input  logic [SRC_W-1:0]                    source_i,
  input  logic [NUM_PORTS-1:0]                target_i,
  input  logic [1:0]                          type_i,
  input  logic [DATA_W-1:0]                   data_i,
  input  logic                                rd_en_i,
  output logic                                rd_valid_o,
  output logic [SRC_W-1:0]                    rd_source_o,
  output logic [1:0]                          rd_type_o,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [LVL_W-1:0]                    level_o,
  input  logic                                clr_i,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]     src_cnt_o,
  output logic [CNT_W-1:0]                    misroute_cnt_o,
  output logic [CNT_W-1:0]                    overflow_cnt_o
);

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    pkt_type_e         ptype;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic routed, can_write, push, drop, misroute;
  entry_t wr_entry, rd_entry;

  logic [NUM_PORTS-1:0][CNT_W-1:0] src_cnt_q, src_cnt_d;
  logic [CNT_W-1:0]                misroute_cnt_q, misroute_cnt_d;
  logic [CNT_W-1:0]                overflow_cnt_q, overflow_cnt_d;

  // valid_i has no ready: every valid cycle is stored, dropped as overflow, or counted
  // as a misroute in that same cycle. A full FIFO still accepts when a pop frees a slot.
  assign routed    = target_i[PORT_ID];
  assign can_write = !full_o || rd_en_i;
  assign push      = valid_i && routed && can_write;
  assign drop      = valid_i && routed && !can_write;
  assign misroute  = valid_i && !routed;

  assign wr_entry = '{source: source_i, ptype: pkt_type_e'(type_i), data: data_i};

  rx_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (wr_entry),
    .pop_i       (rd_en_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_entry),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  assign rd_source_o = rd_entry.source;
  assign rd_type_o   = rd_entry.ptype;
  assign rd_data_o   = rd_entry.data;

  // Clear wins over a coincident increment; all counters stick at all-ones.
  always_comb begin
    src_cnt_d      = src_cnt_q;
    misroute_cnt_d = misroute_cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    if (clr_i) begin
      src_cnt_d      = '0;
      misroute_cnt_d = '0;
      overflow_cnt_d = '0;
    end else begin
      if (push && (src_cnt_q[source_i] != '1))
        src_cnt_d[source_i] = src_cnt_q[source_i] + CNT_W'(1);
      if (misroute && (misroute_cnt_q != '1))
        misroute_cnt_d = misroute_cnt_q + CNT_W'(1);
      if (drop && (overflow_cnt_q != '1))
        overflow_cnt_d = overflow_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_cnt_q      <= '0;
      misroute_cnt_q <= '0;
      overflow_cnt_q <= '0;
    end else begin
      src_cnt_q      <= src_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign src_cnt_o      = src_cnt_q;
  assign misroute_cnt_o = misroute_cnt_q;
  assign overflow_cnt_o = overflow_cnt_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Bench for switch_port_rx: vector tables with a read-data scoreboard plus hand sequences.
module tb_switch_port_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int PID   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 valid_i;
  logic [1:0]           source_i;
  logic [3:0]           target_i;
  logic [1:0]           type_i;
  logic [DW-1:0]        data_i;
  logic                 rd_en_i;
  logic                 rd_valid_o;
  logic [1:0]           rd_source_o;
  logic [1:0]           rd_type_o;
  logic [DW-1:0]        rd_data_o;
  logic                 empty_o;
  logic                 full_o;
  logic [LW-1:0]        level_o;
  logic                 clr_i;
  logic [3:0][CW-1:0]   src_cnt_o;
  logic [CW-1:0]        misroute_cnt_o;
  logic [CW-1:0]        overflow_cnt_o;

  switch_port_rx #(
    .PORT_ID (PID),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .source_i       (source_i),
    .target_i       (target_i),
    .type_i         (type_i),
    .data_i         (data_i),
    .rd_en_i        (rd_en_i),
    .rd_valid_o     (rd_valid_o),
    .rd_source_o    (rd_source_o),
    .rd_type_o      (rd_type_o),
    .rd_data_o      (rd_data_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .level_o        (level_o),
    .clr_i          (clr_i),
    .src_cnt_o      (src_cnt_o),
    .misroute_cnt_o (misroute_cnt_o),
    .overflow_cnt_o (overflow_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic       v;
    logic [1:0] src;
    logic [3:0] tgt;
    logic [1:0] ty;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       stored;
    int         lvl;
    logic       rdv;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          exp_src[4];
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] src, input logic [3:0] tgt,
                              input logic rd, input logic clr, input logic stored,
                              input int lvl, input logic rdv);
    vec_t t;
    t.v      = v;
    t.src    = src;
    t.tgt    = tgt;
    t.ty     = 2'($urandom_range(0, 3));
    t.d      = 8'($urandom_range(0, 255)) | 8'h01;
    t.rd     = rd;
    t.clr    = clr;
    t.stored = stored;
    t.lvl    = lvl;
    t.rdv    = rdv;
    return t;
  endfunction

  function automatic logic [1:0] rsrc();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic idle_inputs();
    valid_i  = 1'b0;
    source_i = '0;
    target_i = '0;
    type_i   = '0;
    data_i   = '0;
    rd_en_i  = 1'b0;
    clr_i    = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    logic [11:0] e;
    valid_i  = t.v;
    source_i = t.src;
    target_i = t.tgt;
    type_i   = t.ty;
    data_i   = t.d;
    rd_en_i  = t.rd;
    clr_i    = t.clr;
    if (t.clr) for (int s = 0; s < 4; s++) exp_src[s] = 0;
    if (t.stored) begin
      exp_q.push_back({t.src, t.ty, t.d});
      if (!t.clr && exp_src[t.src] < 15) exp_src[t.src]++;
    end
    @(posedge clk);
    #1;
    check({tag, " level"}, 32'(level_o), 32'(t.lvl));
    check({tag, " empty"}, 32'(empty_o), 32'(t.lvl == 0));
    check({tag, " full"}, 32'(full_o), 32'(t.lvl == DEPTH));
    check({tag, " rd_valid"}, 32'(rd_valid_o), 32'(t.rdv));
    if (rd_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s rd_entry: got %0h expected none queued", tag,
                 {rd_source_o, rd_type_o, rd_data_o});
      end else begin
        e = exp_q.pop_front();
        total--;
        check({tag, " rd_entry"}, 32'({rd_source_o, rd_type_o, rd_data_o}), 32'(e));
      end
    end
    idle_inputs();
  endtask

  task automatic run_all(input string tag);
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  task automatic check_src(input string tag);
    for (int s = 0; s < 4; s++)
      check($sformatf("%s src_cnt[%0d]", tag, s), 32'(src_cnt_o[s]), 32'(exp_src[s]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    for (int s = 0; s < 4; s++) exp_src[s] = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset level", 32'(level_o), 0);
    check("reset empty", 32'(empty_o), 1);
    check("reset full", 32'(full_o), 0);
    check("reset rd_valid", 32'(rd_valid_o), 0);
    check("reset misroute", 32'(misroute_cnt_o), 0);
    check_src("reset");
    rst_n = 1'b1;

    // Basic: three packets from sources 0,1,3, then three pops and one pop on empty.
    vecs.push_back(mk(1, 2'd0, 4'b0100, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'd1, 4'b0100, 0, 0, 1, 2, 0));
    vecs.push_back(mk(1, 2'd3, 4'b0100, 0, 0, 1, 3, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 2 - i, 1));
    vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 0, 0));
    run_all("basic");
    check("basic src_cnt[0]", 32'(src_cnt_o[0]), 1);
    check("basic src_cnt[1]", 32'(src_cnt_o[1]), 1);
    check("basic src_cnt[2]", 32'(src_cnt_o[2]), 0);
    check("basic src_cnt[3]", 32'(src_cnt_o[3]), 1);

    // Misroutes are counted but never stored; a multicast including this port is stored.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, rsrc(), 4'b1011, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 4'b0111, 0, 0, 1, 1, 0));
    run_all("misroute");
    check("misroute count", 32'(misroute_cnt_o), 5);
    vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 0, 1));
    // Push and pop together on empty: the push lands, the pop is ignored.
    vecs.push_back(mk(1, 2'd1, 4'b0100, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 0, 1));
    run_all("empty_edge");

    // Ten packets with no reads: eight stored, two dropped.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, rsrc(), 4'(4'b0100 | 4'($urandom_range(0, 15))), 0, 0,
                        i < 8, (i < 8) ? i + 1 : 8, 0));
    run_all("fill");
    check("overflow count", 32'(overflow_cnt_o), 2);
    // Full plus pop still accepts the push; then drain back-to-back.
    vecs.push_back(mk(1, rsrc(), 4'b0100, 1, 0, 1, 8, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 7 - i, 1));
    run_all("full_pop");
    check("full_pop overflow", 32'(overflow_cnt_o), 2);
    check("full_pop misroute", 32'(misroute_cnt_o), 5);
    check_src("full_pop");

    // Saturation and clear; the FIFO keeps its five entries across the clear.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, rsrc(), 4'b0100, 0, 0, 1, i + 1, 0));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(1, rsrc(), 4'b1011, 0, 0, 0, 5, 0));
    run_all("saturate");
    check("misroute saturated", 32'(misroute_cnt_o), 15);
    vecs.push_back(mk(1, rsrc(), 4'b1011, 0, 1, 0, 5, 0));
    run_all("clear");
    check("clear misroute", 32'(misroute_cnt_o), 0);
    check("clear overflow", 32'(overflow_cnt_o), 0);
    check_src("clear");
    vecs.push_back(mk(1, rsrc(), 4'b1011, 0, 0, 0, 5, 0));
    vecs.push_back(mk(1, 2'd3, 4'b0100, 1, 0, 1, 5, 1));
    run_all("post_clear");
    check("post_clear misroute", 32'(misroute_cnt_o), 1);
    check_src("post_clear");

    // Reset in the middle of traffic, with a valid packet and a pop in the reset cycle.
    rst_n    = 1'b0;
    valid_i  = 1'b1;
    source_i = 2'd3;
    target_i = 4'b0100;
    type_i   = 2'd1;
    data_i   = 8'h5a;
    rd_en_i  = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int s = 0; s < 4; s++) exp_src[s] = 0;
    check("rst level", 32'(level_o), 0);
    check("rst empty", 32'(empty_o), 1);
    check("rst full", 32'(full_o), 0);
    check("rst rd_valid", 32'(rd_valid_o), 0);
    check("rst rd_fields", 32'({rd_source_o, rd_type_o, rd_data_o}), 0);
    check("rst misroute", 32'(misroute_cnt_o), 0);
    check("rst overflow", 32'(overflow_cnt_o), 0);
    check_src("rst");
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("after_rst level", 32'(level_o), 0);
    check("after_rst src_cnt[3]", 32'(src_cnt_o[3]), 0);
    vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 4'b0100, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 0, 0, 1));
    run_all("after_rst");
    check_src("after_rst");
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
